// File: rtl/comparator_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : comparator_pkg
//  Description : Shared definitions for the serial magnitude comparator:
//                result-select mode encodings, FSM state encodings and the
//                mode-to-result helper.
//  Revision    : 1.0  initial release
// ============================================================================
package comparator_pkg;

    // Result-select encodings carried on the mode input
    localparam logic [1:0] MODE_GT = 2'b00;
    localparam logic [1:0] MODE_LT = 2'b01;
    localparam logic [1:0] MODE_EQ = 2'b10;
    localparam logic [1:0] MODE_GE = 2'b11;

    // Controller states
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        SCAN = 2'b01,
        DONE = 2'b10
    } state_t;

    // Pick the flag that the captured mode asks for
    function automatic logic select_result(
        input logic [1:0] mode,
        input logic       gt,
        input logic       eq,
        input logic       lt
    );
        logic r;
        case (mode)
            MODE_GT: r = gt;
            MODE_LT: r = lt;
            MODE_EQ: r = eq;
            default: r = gt | eq;
        endcase
        return r;
    endfunction

endpackage : comparator_pkg
`default_nettype wire

// File: rtl/comparator_digit.sv
`default_nettype none
// ============================================================================
//  Module      : comparator_digit
//  Description : Combinational compare of one DIGIT-bit slice of A and B.
//                Produces gt (A slice > B slice) and eq (slices identical).
//                With COMPARATOR_SIGNED_EN defined, the slice flagged by
//                is_msb_slice treats its top bit as a negatively weighted
//                sign bit.
//  Macro       : COMPARATOR_SIGNED_EN (two's-complement operands)
//  Ports       : a_i, b_i      [DIGIT-1:0]  operand slices
//                is_msb_slice  1            slice holds the sign bit
//                gt_o, eq_o    1            slice compare flags
//  Revision    : 1.0  initial release
// ============================================================================
module comparator_digit #(
    parameter int DIGIT = 2
) (
    input  logic [DIGIT-1:0] a_i,
    input  logic [DIGIT-1:0] b_i,
    input  logic             is_msb_slice,
    output logic             gt_o,
    output logic             eq_o
);

`ifdef COMPARATOR_SIGNED_EN
    localparam bit c_SIGNED_EN = 1'b1;
`else
    localparam bit c_SIGNED_EN = 1'b0;
`endif

    logic             w_flip;
    logic [DIGIT-1:0] w_a;
    logic [DIGIT-1:0] w_b;

    assign w_flip = c_SIGNED_EN & is_msb_slice;

    // Inverting the sign bit of both operands maps two's-complement order
    // onto unsigned order, so one unsigned compare serves both cases.
    always_comb begin
        w_a            = a_i;
        w_b            = b_i;
        w_a[DIGIT-1]   = a_i[DIGIT-1] ^ w_flip;
        w_b[DIGIT-1]   = b_i[DIGIT-1] ^ w_flip;
    end

    assign gt_o = (w_a > w_b);
    assign eq_o = (a_i == b_i);

endmodule : comparator_digit
`default_nettype wire

// File: rtl/comparator_magnitude_serial.sv
`default_nettype none
// ============================================================================
//  Module      : comparator_magnitude_serial
//  Description : Handshaked multi-cycle magnitude comparator. Scans the
//                captured operands MSB-first, DIGIT bits per cycle, stopping
//                at the first differing slice, and holds registered
//                gt/eq/lt flags plus a mode-selected result bit until the
//                consumer accepts them.
//  Macro       : COMPARATOR_SIGNED_EN (two's-complement operands)
//  Ports       : clk, rst               clock, synchronous active-high reset
//                in_valid / in_ready    request handshake
//                a, b      [WIDTH-1:0]  operands
//                mode      [1:0]        00 A>B, 01 A<B, 10 A==B, 11 A>=B
//                out_valid / out_ready  result handshake
//                gt, eq, lt, result     registered outputs
//  Revision    : 1.0  initial release
// ============================================================================
module comparator_magnitude_serial
    import comparator_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DIGIT = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [1:0]       mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             gt,
    output logic             eq,
    output logic             lt,
    output logic             result
);

    localparam int NSLICE = WIDTH / DIGIT;
    localparam int CW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [CW-1:0] LAST_IDX = CW'(NSLICE - 1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [1:0]       mode_q, mode_d;
    logic [CW-1:0]    idx_q, idx_d;
    logic             gt_q, gt_d;
    logic             eq_q, eq_d;
    logic             lt_q, lt_d;
    logic             result_q, result_d;

    logic [DIGIT-1:0] w_slice_a;
    logic [DIGIT-1:0] w_slice_b;
    logic             w_dig_gt;
    logic             w_dig_eq;

    // Current slice, MSB first: slice i covers [WIDTH-1-i*DIGIT -: DIGIT]
    always_comb begin
        w_slice_a = '0;
        w_slice_b = '0;
        for (int i = 0; i < NSLICE; i++) begin
            if (idx_q == CW'(i)) begin
                w_slice_a = a_q[WIDTH-1-i*DIGIT -: DIGIT];
                w_slice_b = b_q[WIDTH-1-i*DIGIT -: DIGIT];
            end
        end
    end

    comparator_digit #(
        .DIGIT (DIGIT)
    ) u_digit (
        .a_i          (w_slice_a),
        .b_i          (w_slice_b),
        .is_msb_slice (idx_q == '0),
        .gt_o         (w_dig_gt),
        .eq_o         (w_dig_eq)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            mode_q   <= '0;
            idx_q    <= '0;
            gt_q     <= 1'b0;
            eq_q     <= 1'b0;
            lt_q     <= 1'b0;
            result_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            mode_q   <= mode_d;
            idx_q    <= idx_d;
            gt_q     <= gt_d;
            eq_q     <= eq_d;
            lt_q     <= lt_d;
            result_q <= result_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        mode_d   = mode_q;
        idx_d    = idx_q;
        gt_d     = gt_q;
        eq_d     = eq_q;
        lt_d     = lt_q;
        result_d = result_q;

        case (state_q)
            IDLE: begin
                // in_ready is 1 throughout IDLE
                if (in_valid) begin
                    a_d     = a;
                    b_d     = b;
                    mode_d  = mode;
                    idx_d   = '0;
                    state_d = SCAN;
                end
            end
            SCAN: begin
                if (!w_dig_eq) begin
                    gt_d     = w_dig_gt;
                    lt_d     = ~w_dig_gt;
                    eq_d     = 1'b0;
                    result_d = select_result(mode_q, w_dig_gt, 1'b0, ~w_dig_gt);
                    state_d  = DONE;
                end else if (idx_q == LAST_IDX) begin
                    gt_d     = 1'b0;
                    lt_d     = 1'b0;
                    eq_d     = 1'b1;
                    result_d = select_result(mode_q, 1'b0, 1'b1, 1'b0);
                    state_d  = DONE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            DONE: begin
                // Consuming the result returns to IDLE; a new request can
                // only be taken from the following cycle on.
                if (out_ready) begin
                    gt_d     = 1'b0;
                    eq_d     = 1'b0;
                    lt_d     = 1'b0;
                    result_d = 1'b0;
                    state_d  = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign gt        = gt_q;
    assign eq        = eq_q;
    assign lt        = lt_q;
    assign result    = result_q;

endmodule : comparator_magnitude_serial
`default_nettype wire

// File: tb/tb_comparator_magnitude_serial.sv
`default_nettype none
// ============================================================================
//  Module      : tb_comparator_magnitude_serial
//  Description : Self-checking bench for comparator_magnitude_serial
//                (WIDTH=8, DIGIT=2). Expected flags, result and latency come
//                from a behavioural model and travel through a scoreboard
//                queue. Honours COMPARATOR_SIGNED_EN like the design.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_comparator_magnitude_serial;

    localparam int WIDTH  = 8;
    localparam int DIGIT  = 2;
    localparam int NSLICE = WIDTH / DIGIT;

    typedef struct {
        logic gt;
        logic eq;
        logic lt;
        logic res;
        int   lat;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [1:0]       mode;
    logic             out_valid;
    logic             out_ready;
    logic             gt, eq, lt, result;

    int   vectors     = 0;
    int   miscompares = 0;
    exp_t sb[$];

    comparator_magnitude_serial #(
        .WIDTH (WIDTH),
        .DIGIT (DIGIT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .mode      (mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .gt        (gt),
        .eq        (eq),
        .lt        (lt),
        .result    (result)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic exp_t model(input logic [WIDTH-1:0] ma, input logic [WIDTH-1:0] mb,
                                   input logic [1:0] mm);
        exp_t e;
        int   first;
        logic [WIDTH-1:0] sa;
        logic [WIDTH-1:0] sb_;
`ifdef COMPARATOR_SIGNED_EN
        e.gt = ($signed(ma) > $signed(mb));
        e.lt = ($signed(ma) < $signed(mb));
`else
        e.gt = (ma > mb);
        e.lt = (ma < mb);
`endif
        e.eq = (ma == mb);
        case (mm)
            2'b00:   e.res = e.gt;
            2'b01:   e.res = e.lt;
            2'b10:   e.res = e.eq;
            default: e.res = e.gt | e.eq;
        endcase
        first = NSLICE;
        for (int i = NSLICE - 1; i >= 0; i--) begin
            sa  = ma >> ((NSLICE - 1 - i) * DIGIT);
            sb_ = mb >> ((NSLICE - 1 - i) * DIGIT);
            if (sa[DIGIT-1:0] != sb_[DIGIT-1:0]) first = i;
        end
        e.lat = (first == NSLICE) ? NSLICE : first + 1;
        return e;
    endfunction

    // One complete transaction; result held for `hold` cycles before consume.
    task automatic run(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb_,
                       input logic [1:0] tm, input int hold);
        exp_t e;
        int   cyc;
        sb.push_back(model(ta, tb_, tm));
        chk("in_ready_before_req", 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        a        = ta;
        b        = tb_;
        mode     = tm;
        @(posedge clk); #1;
        // Operands must be ignored once accepted
        in_valid = 1'b0;
        a        = ~ta;
        b        = ~tb_;
        mode     = ~tm;
        cyc      = 0;
        while (!out_valid && cyc < 20) begin
            @(posedge clk); #1;
            cyc++;
        end
        e = sb.pop_front();
        chk("timeout", 32'(out_valid), 32'd1);
        chk("latency", 32'(cyc), 32'(e.lat));
        chk("gt", 32'(gt), 32'(e.gt));
        chk("eq", 32'(eq), 32'(e.eq));
        chk("lt", 32'(lt), 32'(e.lt));
        chk("result", 32'(result), 32'(e.res));
        chk("in_ready_done", 32'(in_ready), 32'd0);
        for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
            chk("hold_valid", 32'(out_valid), 32'd1);
            chk("hold_in_ready", 32'(in_ready), 32'd0);
            chk("hold_flags", {28'd0, gt, eq, lt, result}, {28'd0, e.gt, e.eq, e.lt, e.res});
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("consume_valid", 32'(out_valid), 32'd0);
        chk("consume_in_ready", 32'(in_ready), 32'd1);
        chk("consume_flags", {28'd0, gt, eq, lt, result}, 32'd0);
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        mode      = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_flags", {28'd0, gt, eq, lt, result}, 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Directed cases
        run(8'hC0, 8'h40, 2'b00, 0);   // first slice differs
        run(8'h5A, 8'h5A, 2'b10, 0);   // equal, full scan
        run(8'h12, 8'h13, 2'b11, 0);   // last slice differs, lt
        run(8'h33, 8'h31, 2'b01, 5);   // long hold in DONE
        run(8'h80, 8'h7F, 2'b00, 0);   // sign-sensitive pair
        run(8'hFF, 8'h00, 2'b11, 0);
        run(8'h00, 8'h00, 2'b11, 1);

        // Abort in the second SCAN cycle
        in_valid = 1'b1;
        a        = 8'h00;
        b        = 8'h01;
        mode     = 2'b01;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("abort_in_ready", 32'(in_ready), 32'd1);
        chk("abort_out_valid", 32'(out_valid), 32'd0);
        chk("abort_flags", {28'd0, gt, eq, lt, result}, 32'd0);
        run(8'h00, 8'h01, 2'b01, 0);

        // Random sweep
        for (int r = 0; r < 12; r++) begin
            run(8'($urandom), 8'($urandom), 2'($urandom_range(0, 3)), int'($urandom_range(0, 2)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_comparator_magnitude_serial
`default_nettype wire

// File: doc/comparator_magnitude_serial.md
# comparator_magnitude_serial

Parametrised, handshaked magnitude comparator for WIDTH-bit operands. It scans the operands MSB-first, DIGIT bits per clock, and stops early at the first differing digit. It returns registered GT/EQ/LT flags plus one mode-selected result bit. It is the multi-cycle successor to the 2-bit structural greater-than comparator, and it serves datapaths where wide operands make a single-cycle compare too slow.

## Interface
- WIDTH, 8, operand width in bits; ≥2; must be a multiple of DIGIT
- DIGIT, 2, bits compared per cycle; 1..WIDTH
- clk  input  1  rising-edge clock, the only clock
- rst  input  1  reset, synchronous, active-high
- in_valid  input  1  operand request
- in_ready  output  1  block can accept a request
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- mode  input  2  result select: 00 A>B, 01 A<B, 10 A==B, 11 A>=B
- out_valid  output  1  result held valid
- out_ready  input  1  consumer accepts result
- gt, eq, lt  output  1 each  comparison flags; exactly one is high while out_valid
- result  output  1  flag selected by the captured mode

## Operation
- States: IDLE, SCAN, DONE. Reset enters IDLE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready: capture a, b and mode into registers, clear the digit counter, go to SCAN.
- SCAN:
  - in_ready=0.
  - Each cycle, compare digit slice idx, MSB first. Slice idx covers bits [WIDTH-1-idx*DIGIT -: DIGIT].
  - Slices differ: register gt or lt from that slice, go to DONE.
  - Slices equal and idx is the last slice (WIDTH/DIGIT-1): register eq=1, go to DONE.
  - Otherwise increment idx.
- DONE:
  - out_valid=1. gt/eq/lt/result stay stable until out_ready.
  - On out_valid&&out_ready: go to IDLE and drop out_valid.
- No new request is accepted in the same cycle a result is consumed. in_ready rises one cycle later.
- result: mode 00→gt, 01→lt, 10→eq, 11→gt|eq.
- Digit counter width: clog2(WIDTH/DIGIT), minimum 1 bit. It never wraps past the last slice.
- Inputs a, b and mode are ignored outside the accept cycle. Changing them mid-scan has no effect.
- in_valid held high while not ready is legal and waits; it is not dropped.

## Timing
- Reset values:
  - state=IDLE
  - in_ready=1
  - out_valid=0
  - gt=eq=lt=0, result=0
  - counter=0
  - operand registers=0
- rst asserted mid-SCAN or in DONE aborts the operation. The next cycle is IDLE with all outputs at reset values, and the pending result is lost.
- Latency:
  - Request accepted at edge T: out_valid rises at edge T+k.
  - k = 1 + index of the first differing slice.
  - Equal operands: k = WIDTH/DIGIT.
  - Best case 1 cycle, worst case WIDTH/DIGIT cycles.
- Throughput: one compare per k+2 cycles minimum (accept, scan, consume/return).
- Flags change only on the SCAN→DONE edge. They clear to 0 on the DONE→IDLE edge.

## Configuration
- COMPARATOR_SIGNED_EN:
  - Defined: operands are two's complement. On the first slice only, the sign bit is weighted negatively, so A=8'h80 vs B=8'h7F gives lt.
  - Undefined: operands are unsigned on all slices, so the same pair gives gt.
- Latency and handshake are identical in both builds.

## Structure
- Shared package comparator_pkg:
  - mode encodings MODE_GT=2'b00, MODE_LT=2'b01, MODE_EQ=2'b10, MODE_GE=2'b11
  - state encodings IDLE/SCAN/DONE
- Sub-module comparator_digit: combinational DIGIT-bit slice compare producing gt and eq. It takes an is_msb_slice input that applies the signed weighting when COMPARATOR_SIGNED_EN is defined.
- Top level holds the FSM, digit counter, operand registers and result mux.

## Test plan
- WIDTH=8, DIGIT=2, a=8'hC0, b=8'h40, mode=00 → out_valid at T+1; gt=1, result=1 (unsigned build).
- a=8'h5A, b=8'h5A, mode=10 → out_valid at T+4; eq=1, gt=lt=0, result=1.
- a=8'h12, b=8'h13, mode=11 → differing slice 3, out_valid at T+4; lt=1, result=0.
- out_ready held low 5 cycles in DONE → flags stable, in_ready=0 throughout; in_ready=1 one cycle after the handshake.
- rst pulsed in the 2nd SCAN cycle of a=8'h00, b=8'h01 → next cycle IDLE, out_valid=0, flags=0; a fresh request completes normally.
- COMPARATOR_SIGNED_EN defined, a=8'h80, b=8'h7F, mode=00 → lt=1, result=0 at T+1; same stimulus unsigned → gt=1.
